// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pattern generator: pattern-mode encodings,
// colour field widths and packed pixel type, named colours, and the default
// 640x480@60 timing (25 MHz pixel rate from a 50 MHz board clock).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    typedef enum logic [1:0] {
        MODE_STRIPES = 2'b00,
        MODE_CHECKER = 2'b01,
        MODE_SOLID   = 2'b10,
        MODE_BALL    = 2'b11
    } mode_e;

    // Field order matches the 8-bit solid colour input {r, g, b}.
    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: '0, g: '0, b: '0};
    localparam rgb_t RGB_WHITE = '{r: '1, g: '1, b: '1};
    localparam rgb_t RGB_RED   = '{r: '1, g: '0, b: '0};
    localparam rgb_t RGB_BLUE  = '{r: '0, g: '0, b: '1};

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CW        = 10;
    localparam int DEF_BALL_SIZE = 8;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen_if
// Video output bundle of the pattern generator.
//   hsync, vsync        sync pulses
//   red, green, blue    pixel colour (3/3/2 bits)
//   hc, vc              coordinates of the pixel currently on red/green/blue
//   vidon               high while that pixel is in the visible area
//   frame_start         one-mclk pulse per frame
// master: the generator driving the connector; slave: anything observing it.
// -----------------------------------------------------------------------------
interface vga_pattern_gen_if
    import vga_pkg::*;
#(
    parameter int CW = DEF_CW
) ();

    logic           hsync;
    logic           vsync;
    logic [R_W-1:0] red;
    logic [G_W-1:0] green;
    logic [B_W-1:0] blue;
    logic [CW-1:0]  hc;
    logic [CW-1:0]  vc;
    logic           vidon;
    logic           frame_start;

    modport master (
        output hsync, vsync, red, green, blue, hc, vc, vidon, frame_start
    );

    modport slave (
        input hsync, vsync, red, green, blue, hc, vc, vidon, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Pixel-clock-enable divider plus horizontal/vertical counters with sync and
// visible-area decode. All outputs describe the current (unregistered) counts.
//   mclk, clr_n    clock and synchronous active-low reset
//   pix_en         one mclk in every CLK_DIV; counters advance on it
//   hcnt, vcnt     current pixel / line count (visible area starts at 0)
//   hsync, vsync   decoded sync levels for hcnt/vcnt
//   visible        hcnt/vcnt inside the visible area
//   frame_wrap     pix_en on which the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CW        = DEF_CW
) (
    input  logic          mclk,
    input  logic          clr_n,
    output logic          pix_en,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          visible,
    output logic          frame_wrap
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    // A 1-bit divider that never leaves 0 keeps pix_en permanently high for CLK_DIV=1.
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS        = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS        = CW'(V_VISIBLE);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          h_last, v_last;

    assign pix_en = (div_q == DIV_LAST);
    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        div_d  = pix_en ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (!clr_n) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt       = hcnt_q;
    assign vcnt       = vcnt_q;
    assign hsync      = (hcnt_q >= H_SYNC_FIRST && hcnt_q <= H_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    assign vsync      = (vcnt_q >= V_SYNC_FIRST && vcnt_q <= V_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    assign visible    = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign frame_wrap = pix_en && h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// VGA timing plus a one-stage pattern renderer (stripes, checkerboard, solid
// colour, bouncing ball). The render stage registers coordinates, syncs,
// vidon and colour together on pix_en, so they always describe one pixel.
//   mclk, clr_n   board clock and synchronous active-low reset
//   mode          pattern select (vga_pkg::mode_e encoding)
//   color         solid-mode colour {r[2:0], g[2:0], b[1:0]}
//   vga           video output bundle (master side)
// -----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CW        = DEF_CW,
    parameter int BALL_SIZE = DEF_BALL_SIZE
) (
    input  logic              mclk,
    input  logic              clr_n,
    input  logic [1:0]        mode,
    input  logic [7:0]        color,
    vga_pattern_gen_if.master vga
);

    localparam logic [CW-1:0] BX_MAX   = CW'(H_VISIBLE - BALL_SIZE);
    localparam logic [CW-1:0] BY_MAX   = CW'(V_VISIBLE - BALL_SIZE);
    localparam logic [CW:0]   BALL_EXT = (CW + 1)'(BALL_SIZE);

    typedef struct packed {
        logic [CW-1:0] pos;
        logic          neg;   // 1: moving towards 0
    } axis_t;

    // One frame step of a bouncing coordinate: reverse at an edge and move in
    // the new direction within the same update.
    function automatic axis_t bounce(input axis_t cur, input logic [CW-1:0] max_pos);
        axis_t nxt;
        nxt.neg = (cur.neg ? (cur.pos == '0) : (cur.pos == max_pos)) ? ~cur.neg : cur.neg;
        nxt.pos = nxt.neg ? cur.pos - 1'b1 : cur.pos + 1'b1;
        return nxt;
    endfunction

    logic          pix_en, frame_wrap, visible, h_sync, v_sync;
    logic [CW-1:0] hcnt, vcnt;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL (SYNC_POL),
        .CW       (CW)
    ) u_timing (
        .mclk      (mclk),
        .clr_n     (clr_n),
        .pix_en    (pix_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync     (h_sync),
        .vsync     (v_sync),
        .visible   (visible),
        .frame_wrap(frame_wrap)
    );

    axis_t         bx_q, by_q;
    logic [CW-1:0] hc_q, vc_q;
    logic          hsync_q, vsync_q, vidon_q, frame_start_q;
    rgb_t          rgb_q, rgb_d;
    logic          in_ball;

    // Widened by one bit so bx+BALL_SIZE cannot wrap near the counter limit.
    assign in_ball = ({1'b0, hcnt} >= {1'b0, bx_q.pos}) && ({1'b0, hcnt} < {1'b0, bx_q.pos} + BALL_EXT)
                  && ({1'b0, vcnt} >= {1'b0, by_q.pos}) && ({1'b0, vcnt} < {1'b0, by_q.pos} + BALL_EXT);

    always_comb begin
        rgb_d = RGB_BLACK;
        if (visible) begin
            case (mode_e'(mode))
                MODE_STRIPES: rgb_d = vcnt[4] ? RGB_BLUE : RGB_RED;
                MODE_CHECKER: rgb_d = (hcnt[5] ^ vcnt[5]) ? RGB_WHITE : RGB_BLACK;
                MODE_SOLID:   rgb_d = rgb_t'(color);
                MODE_BALL:    rgb_d = in_ball ? RGB_WHITE : RGB_BLACK;
                default:      rgb_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!clr_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            vidon_q       <= 1'b0;
            rgb_q         <= RGB_BLACK;
            frame_start_q <= 1'b0;
            bx_q          <= '{pos: '0, neg: 1'b0};
            by_q          <= '{pos: '0, neg: 1'b0};
        end else begin
            // Registered every mclk so the pulse is one mclk wide, not one pixel.
            frame_start_q <= frame_wrap;
            if (pix_en) begin
                hc_q    <= hcnt;
                vc_q    <= vcnt;
                hsync_q <= h_sync;
                vsync_q <= v_sync;
                vidon_q <= visible;
                rgb_q   <= rgb_d;
            end
            // The wrap pixel is never visible, so moving the ball here cannot tear it.
            if (frame_wrap) begin
                bx_q <= bounce(bx_q, BX_MAX);
                by_q <= bounce(by_q, BY_MAX);
            end
        end
    end

    assign vga.hc          = hc_q;
    assign vga.vc          = vc_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vidon       = vidon_q;
    assign vga.red         = rgb_q.r;
    assign vga.green       = rgb_q.g;
    assign vga.blue        = rgb_q.b;
    assign vga.frame_start = frame_start_q;

endmodule
